inst_trace_buf: RTL and testbench

INST_TRACE_BUF -- requirements
Module: inst_trace_buf

---
 rtl/inst_trace_buf.sv | 120 ++++++++++++
 tb/tb_inst_trace_buf.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_trace_buf.sv
// Instruction trace buffer: captures retiring {PC, instruction} pairs from the ID
// stage into a circular FIFO, with optional PC trigger and stop-or-wrap full policy.
module inst_trace_buf #(
  parameter int DEPTH = 64,
  parameter int PCW   = 30,
  parameter int WRAP  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ic_stall,
  input  logic                     ic_stall_dly,
  input  logic                     stall,
  input  logic                     stall_ld,
  input  logic                     jmp_cond,
  input  logic                     post_jump_cmd_c,
  input  logic [PCW-1:0]           pc_id,
  input  logic [31:0]              inst_id,
  input  logic                     trace_en,
  input  logic                     trig_en,
  input  logic [PCW-1:0]           trig_pc,
  input  logic                     clear,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [PCW+1:0]           rd_pc,
  output logic [31:0]              rd_inst,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic                     triggered
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam bit WRAP_MODE = (WRAP != 0);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t          state;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [PCW+31:0] mem [DEPTH];

  logic retire;
  logic pop;
  logic hit;
  logic wr_en;
  logic drop;
  logic overwrite;
  logic stop;

  assign retire = ~(ic_stall | ic_stall_dly | stall | stall_ld | jmp_cond | post_jump_cmd_c);
  assign rd_valid = (count != '0);
  assign full     = (count == CW'(DEPTH));
  assign pop      = rd_valid & rd_ready;

  // A retire is a capture candidate only while capturing, or on the trigger hit itself.
  assign hit = retire & trace_en &
               ((state == CAPTURE) | ((state == ARMED) & (pc_id == trig_pc)));

  // A full buffer only loses data when nothing is popped on the same edge.
  assign drop      = hit & full & ~pop;
  assign wr_en     = hit & (~full | pop | WRAP_MODE);
  assign overwrite = drop & WRAP_MODE;
  assign stop      = drop & ~WRAP_MODE;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      triggered <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      triggered <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop || overwrite) rd_ptr <= rd_ptr + AW'(1);

      if (wr_en && !pop && !overwrite) count <= count + CW'(1);
      else if (pop && !wr_en)          count <= count - CW'(1);

      if (drop) overflow <= 1'b1;

      if (!trace_en) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:    state <= trig_en ? ARMED : CAPTURE;
          ARMED: begin
            if (hit) begin
              triggered <= 1'b1;
              state     <= stop ? DONE : CAPTURE;
            end
          end
          CAPTURE: if (stop) state <= DONE;
          DONE:    state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // NOTE: the trace array has no reset; count gates visibility, so stale contents
  // are never presented, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {pc_id, inst_id};
  end

  assign rd_pc   = {mem[rd_ptr][PCW+31:32], 2'b00};
  assign rd_inst = mem[rd_ptr][31:0];

endmodule

// File: tb/tb_inst_trace_buf.sv
// Scoreboard bench: two DEPTH=4 instances (stop and wrap policies) share stimulus;
// expected entries are queued per instance and checked by a pop monitor.
module tb_inst_trace_buf;

  localparam int DEPTH = 4;
  localparam int PCW   = 30;
  localparam logic [5:0] QIDLE = 6'b000100;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       qual = QIDLE;
  logic [PCW-1:0]   pc_id = '0;
  logic [31:0]      inst_id = '0;
  logic             trace_en = 1'b0;
  logic             trig_en = 1'b0;
  logic [PCW-1:0]   trig_pc = '0;
  logic             clear = 1'b0;
  logic             rd_ready = 1'b0;

  logic             rd_valid0, rd_valid1;
  logic [PCW+1:0]   rd_pc0, rd_pc1;
  logic [31:0]      rd_inst0, rd_inst1;
  logic [2:0]       count0, count1;
  logic             full0, full1, overflow0, overflow1, triggered0, triggered1;

  int total = 0;
  int bad   = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  always #5 clk = ~clk;

  inst_trace_buf #(.DEPTH(DEPTH), .PCW(PCW), .WRAP(0)) u_stop (
    .clk(clk), .rst_n(rst_n),
    .ic_stall(qual[0]), .ic_stall_dly(qual[1]), .stall(qual[2]),
    .stall_ld(qual[3]), .jmp_cond(qual[4]), .post_jump_cmd_c(qual[5]),
    .pc_id(pc_id), .inst_id(inst_id), .trace_en(trace_en), .trig_en(trig_en),
    .trig_pc(trig_pc), .clear(clear), .rd_ready(rd_ready),
    .rd_valid(rd_valid0), .rd_pc(rd_pc0), .rd_inst(rd_inst0), .count(count0),
    .full(full0), .overflow(overflow0), .triggered(triggered0)
  );

  inst_trace_buf #(.DEPTH(DEPTH), .PCW(PCW), .WRAP(1)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .ic_stall(qual[0]), .ic_stall_dly(qual[1]), .stall(qual[2]),
    .stall_ld(qual[3]), .jmp_cond(qual[4]), .post_jump_cmd_c(qual[5]),
    .pc_id(pc_id), .inst_id(inst_id), .trace_en(trace_en), .trig_en(trig_en),
    .trig_pc(trig_pc), .clear(clear), .rd_ready(rd_ready),
    .rd_valid(rd_valid1), .rd_pc(rd_pc1), .rd_inst(rd_inst1), .count(count1),
    .full(full1), .overflow(overflow1), .triggered(triggered1)
  );

  function automatic logic [31:0] mk_inst(input logic [PCW-1:0] pc);
    return 32'hC0DE_0000 ^ {2'b00, pc};
  endfunction

  function automatic logic [63:0] ent(input logic [PCW-1:0] pc);
    return {pc, 2'b00, mk_inst(pc)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // p0/p1 say whether each instance is expected to store this entry; the wrap
  // instance drops its oldest queued entry when it overwrites.
  task automatic retire(input logic [PCW-1:0] pc, input bit p0, input bit p1, input bit rdy);
    qual     = '0;
    pc_id    = pc;
    inst_id  = mk_inst(pc);
    rd_ready = rdy;
    if (p0) q0.push_back(ent(pc));
    if (p1) begin
      if (q1.size() == DEPTH && !rdy) void'(q1.pop_front());
      q1.push_back(ent(pc));
    end
    step();
    qual     = QIDLE;
    rd_ready = 1'b0;
  endtask

  task automatic drain(input string name);
    rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (count0 == 0 && count1 == 0) break;
      step();
    end
    rd_ready = 1'b0;
    check({name, "_counts"}, {58'd0, count0, count1}, 64'd0);
    check({name, "_q_left"}, 64'(q0.size() + q1.size()), 64'd0);
  endtask

  task automatic check_flags(input string name, input logic [2:0] cnt, input bit fl,
                             input bit ov0, input bit ov1, input bit tr);
    check({name, "_cnt0"}, 64'(count0), 64'(cnt));
    check({name, "_cnt1"}, 64'(count1), 64'(cnt));
    check({name, "_full"}, {62'd0, full0, full1}, {62'd0, fl, fl});
    check({name, "_ovf"},  {62'd0, overflow0, overflow1}, {62'd0, ov0, ov1});
    check({name, "_trig"}, {62'd0, triggered0, triggered1}, {62'd0, tr, tr});
  endtask

  // Pop monitor: compares the head of each instance against its queue whenever
  // a pop will occur on the coming rising edge.
  always @(negedge clk) begin
    if (rst_n && !clear && rd_ready) begin
      if (rd_valid0) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL pop0_unexpected: got %0h expected none", {rd_pc0, rd_inst0});
        end else check("pop0", {rd_pc0, rd_inst0}, q0.pop_front());
      end
      if (rd_valid1) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL pop1_unexpected: got %0h expected none", {rd_pc1, rd_inst1});
        end else check("pop1", {rd_pc1, rd_inst1}, q1.pop_front());
      end
    end
  end

  initial begin
    #12;
    check_flags("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_valid", {62'd0, rd_valid0, rd_valid1}, 64'd0);
    rst_n = 1'b1;
    step();

    // Plain capture, popped in order
    trace_en = 1'b1;
    step();
    for (int i = 0; i < 3; i++) retire(PCW'(32'h400 + i), 1'b1, 1'b1, 1'b0);
    check_flags("basic", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    check("basic_head", {rd_pc0, rd_pc1}, {32'h1000, 32'h1000});
    drain("basic");

    // Triggered capture starts at trig_pc
    trace_en = 1'b0;
    step();
    trig_en  = 1'b1;
    trig_pc  = PCW'(32'h405);
    trace_en = 1'b1;
    step();
    for (int i = 0; i < 5; i++) retire(PCW'(32'h400 + i), 1'b0, 1'b0, 1'b0);
    check_flags("armed", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 5; i < 8; i++) retire(PCW'(32'h400 + i), 1'b1, 1'b1, 1'b0);
    check_flags("trig", 3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    check("trig_head", {rd_pc0, rd_pc1}, {32'h1014, 32'h1014});
    drain("trig");

    // Clear drops the sticky trigger and returns to IDLE
    trig_en = 1'b0;
    clear   = 1'b1;
    step();
    clear   = 1'b0;
    check_flags("clear1", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // Overflow: stop instance keeps the first four, wrap instance the last four
    for (int i = 0; i < 6; i++) retire(PCW'(32'h400 + i), i < 4, 1'b1, 1'b0);
    check_flags("ovf", 3'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    check("ovf_head", {rd_pc0, rd_pc1}, {32'h1000, 32'h1008});
    drain("ovf");
    retire(PCW'(32'h410), 1'b0, 1'b1, 1'b0);
    check("done_cnt0", 64'(count0), 64'd0);
    check("done_cnt1", 64'(count1), 64'd1);
    drain("done");

    // Full buffer: simultaneous retire and pop, then gated retires
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    for (int i = 0; i < 4; i++) retire(PCW'(32'h500 + i), 1'b1, 1'b1, 1'b0);
    check_flags("fill", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    retire(PCW'(32'h504), 1'b1, 1'b1, 1'b1);
    check_flags("rdwr", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int q = 0; q < 6; q++) begin
      qual  = 6'(1 << q);
      pc_id = PCW'(32'h600);
      step();
    end
    qual = QIDLE;
    check_flags("qual", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    check("qual_head", {rd_pc0, rd_pc1}, {32'h1404, 32'h1404});
    drain("rdwr");

    // Clear beats a same-cycle retire and pop
    retire(PCW'(32'h700), 1'b1, 1'b1, 1'b0);
    retire(PCW'(32'h701), 1'b1, 1'b1, 1'b0);
    clear    = 1'b1;
    qual     = '0;
    pc_id    = PCW'(32'h702);
    rd_ready = 1'b1;
    step();
    clear    = 1'b0;
    rd_ready = 1'b0;
    qual     = QIDLE;
    q0.delete();
    q1.delete();
    check_flags("clear2", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("clear2_valid", {62'd0, rd_valid0, rd_valid1}, 64'd0);
    step();

    // Asynchronous reset mid-capture
    for (int i = 0; i < 5; i++) retire(PCW'(32'h800 + i), i < 4, 1'b1, 1'b0);
    check_flags("pre_rst", 3'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check_flags("async_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("async_rst_valid", {62'd0, rd_valid0, rd_valid1}, 64'd0);
    q0.delete();
    q1.delete();
    step();
    rst_n = 1'b1;
    retire(PCW'(32'h900), 1'b0, 1'b0, 1'b0);
    check("post_rst_idle", {58'd0, count0, count1}, 64'd0);
    retire(PCW'(32'h901), 1'b1, 1'b1, 1'b0);
    check("post_rst_cap", {58'd0, count0, count1}, {58'd0, 3'd1, 3'd1});
    drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
